wb_dual_mem: RTL and testbench

Parametrised two-channel Wishbone-style memory responder serving the CPU's instruction port (read-only) and data port (read/write) from one shared single-port word array. It replaces the fixed zero-wait instruction/data stubs on the cpu bench. It adds configurable wait states, channel arbitration and optional address-range error signalling. It is synthesizable and sits between the cpu ports (STB_O/ADR_O/DAT_O/WE_O out, AKN_I/INSTR_I/DAT_I in) and the bench.

---
 rtl/wb_dual_mem.sv | 164 ++++++++++++++++
 tb/tb_wb_dual_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dual_mem.sv
// Two-channel Wishbone-style responder sharing one single-port word array.
// Define WB_MEM_ERR_EN to add I_ERR_O/D_ERR_O and out-of-range address detection.
module wb_dual_mem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT     = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              I_STB_I,
  input  logic [ADDR_W-1:0] I_ADR_I,
  output logic              I_AKN_O,
  output logic [DATA_W-1:0] I_DAT_O,
  input  logic              D_STB_I,
  input  logic              D_WE_I,
  input  logic [ADDR_W-1:0] D_ADR_I,
  input  logic [DATA_W-1:0] D_DAT_I,
  output logic              D_AKN_O,
  output logic [DATA_W-1:0] D_DAT_O
`ifdef WB_MEM_ERR_EN
  ,
  output logic              I_ERR_O,
  output logic              D_ERR_O
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT > 0) ? WAIT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              ch_reg;      // 1 = data channel owns the transaction
  logic              we_reg;
  logic              err_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] wdat_reg;
  logic              last_d_reg;
  logic              i_akn_reg, d_akn_reg;
  logic [DATA_W-1:0] i_dat_reg, d_dat_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              any_stb, grant_d, accept, go_resp, live_err;
  logic [ADDR_W-1:0] live_adr;
  logic              sel_ch, sel_we, sel_err, mem_we;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_dat;
  logic              unused_bits;

  assign any_stb  = I_STB_I | D_STB_I;
  // Data wins a tie in fixed mode; in round-robin it wins only if instruction went last.
  assign grant_d  = D_STB_I & (~I_STB_I | (ARB_MODE == 0) | ~last_d_reg);
  assign live_adr = grant_d ? D_ADR_I : I_ADR_I;
  assign accept   = (state_reg == S_IDLE) & any_stb;

`ifdef WB_MEM_ERR_EN
  assign live_err = (live_adr >> (IDX_W + 2)) != '0;
`else
  assign live_err = 1'b0;
`endif

  // With WAIT = 0 the RESP-entry edge is the acceptance edge, so use live inputs then.
  assign sel_ch  = accept ? grant_d : ch_reg;
  assign sel_we  = accept ? (grant_d & D_WE_I) : we_reg;
  assign sel_err = accept ? live_err : err_reg;
  assign sel_idx = accept ? live_adr[IDX_W+1:2] : idx_reg;
  assign sel_dat = accept ? D_DAT_I : wdat_reg;
  assign mem_we  = go_resp & sel_we & ~sel_err & RST_I;

  assign unused_bits = ^{I_ADR_I, D_ADR_I};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    go_resp    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (any_stb) begin
          if (WAIT == 0) begin
            state_next = S_RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
          go_resp    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      ch_reg     <= 1'b0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      idx_reg    <= '0;
      wdat_reg   <= '0;
      last_d_reg <= 1'b1;
      i_akn_reg  <= 1'b0;
      d_akn_reg  <= 1'b0;
      i_dat_reg  <= '0;
      d_dat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        ch_reg     <= grant_d;
        we_reg     <= grant_d & D_WE_I;
        err_reg    <= live_err;
        idx_reg    <= live_adr[IDX_W+1:2];
        wdat_reg   <= D_DAT_I;
        last_d_reg <= grant_d;
      end
      i_akn_reg <= go_resp & ~sel_ch & ~sel_err;
      d_akn_reg <= go_resp &  sel_ch & ~sel_err;
      if (go_resp && (!sel_we || sel_err)) begin
        if (sel_ch) d_dat_reg <= sel_err ? '0 : mem[sel_idx];
        else        i_dat_reg <= sel_err ? '0 : mem[sel_idx];
      end
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge CLK_I) begin
    if (mem_we) mem[sel_idx] <= sel_dat;
  end

`ifdef WB_MEM_ERR_EN
  logic i_err_reg, d_err_reg;
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      i_err_reg <= 1'b0;
      d_err_reg <= 1'b0;
    end else begin
      i_err_reg <= go_resp & ~sel_ch & sel_err;
      d_err_reg <= go_resp &  sel_ch & sel_err;
    end
  end
  assign I_ERR_O = i_err_reg;
  assign D_ERR_O = d_err_reg;
`endif

  assign I_AKN_O = i_akn_reg;
  assign D_AKN_O = d_akn_reg;
  assign I_DAT_O = i_dat_reg;
  assign D_DAT_O = d_dat_reg;

endmodule

// File: tb/tb_wb_dual_mem.sv
// Directed bench for wb_dual_mem: three instances cover WAIT=1/ARB 0, WAIT=0/ARB 1
// and WAIT=5/ARB 0.
module tb_wb_dual_mem;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_n;
  logic [N-1:0]       i_stb, i_akn, i_err;
  logic [N-1:0][31:0] i_adr, i_rdat;
  logic [N-1:0]       d_stb, d_we, d_akn, d_err;
  logic [N-1:0][31:0] d_adr, d_wdat, d_rdat;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    wb_dual_mem #(
      .WAIT    ((gi == 0) ? 1 : ((gi == 1) ? 0 : 5)),
      .ARB_MODE((gi == 1) ? 1 : 0)
    ) u_dut (
      .CLK_I  (clk),
      .RST_I  (rst_n[gi]),
      .I_STB_I(i_stb[gi]),
      .I_ADR_I(i_adr[gi]),
      .I_AKN_O(i_akn[gi]),
      .I_DAT_O(i_rdat[gi]),
      .D_STB_I(d_stb[gi]),
      .D_WE_I (d_we[gi]),
      .D_ADR_I(d_adr[gi]),
      .D_DAT_I(d_wdat[gi]),
      .D_AKN_O(d_akn[gi]),
      .D_DAT_O(d_rdat[gi])
`ifdef WB_MEM_ERR_EN
      ,
      .I_ERR_O(i_err[gi]),
      .D_ERR_O(d_err[gi])
`endif
    );
  end

`ifndef WB_MEM_ERR_EN
  assign i_err = '0;
  assign d_err = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One data-channel transaction; returns read data and edges from STB raise to AKN/ERR.
  task automatic d_xfer(input int k, input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int edges, output logic errf);
    @(negedge clk);
    d_stb[k] = 1'b1; d_we[k] = we; d_adr[k] = adr; d_wdat[k] = wd;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (d_akn[k] || d_err[k]) break;
    end
    errf = d_err[k];
    rd   = d_rdat[k];
    d_stb[k] = 1'b0; d_we[k] = 1'b0;
    $display("[%0t] dut%0d D %s adr=%08h wdat=%08h rdat=%08h edges=%0d err=%0b",
             $time, k, we ? "WR" : "RD", adr, wd, rd, edges, errf);
  endtask

  // Both channels request together and hold STB for three transactions each.
  task automatic arb_run(input int k, output logic [5:0] order, output int nack,
                         output int both);
    int ni, nd, cyc;
    @(negedge clk);
    i_stb[k] = 1'b1; i_adr[k] = 32'h40;
    d_stb[k] = 1'b1; d_we[k] = 1'b0; d_adr[k] = 32'h44;
    ni = 0; nd = 0; cyc = 0; both = 0; order = '0;
    while ((ni < 3 || nd < 3) && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (i_akn[k] && d_akn[k]) both++;
      if (d_akn[k]) begin
        order = {order[4:0], 1'b1};
        nd++;
        $display("[%0t] dut%0d ARB grant=D rdat=%08h", $time, k, d_rdat[k]);
        check("arb_d_data", d_rdat[k], 32'h2222_BBBB);
        if (nd == 3) d_stb[k] = 1'b0;
      end else if (i_akn[k]) begin
        order = {order[4:0], 1'b0};
        ni++;
        $display("[%0t] dut%0d ARB grant=I rdat=%08h", $time, k, i_rdat[k]);
        check("arb_i_data", i_rdat[k], 32'h1111_AAAA);
        if (ni == 3) i_stb[k] = 1'b0;
      end
    end
    i_stb[k] = 1'b0; d_stb[k] = 1'b0;
    nack = ni + nd;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    int          edges, nack, both, n, cyc, last_cyc, gap_bad;
    logic        errf, akn_seen;
    logic [5:0]  order;
    logic [31:0] b2b_exp [3];

    rst_n = '0; i_stb = '0; i_adr = '0; d_stb = '0; d_we = '0; d_adr = '0; d_wdat = '0;
    b2b_exp[0] = 32'h11; b2b_exp[1] = 32'h22; b2b_exp[2] = 32'h33;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_ctl", {28'd0, i_akn[k], d_akn[k], i_err[k], d_err[k]}, 32'd0);
      check("reset_i_dat", i_rdat[k], 32'd0);
      check("reset_d_dat", d_rdat[k], 32'd0);
    end
    rst_n = '1;

    // Write then read back, WAIT=1.
    d_xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, edges, errf);
    check("wr_latency", edges, 32'd2);
    d_xfer(0, 1'b0, 32'h10, 32'h0, rd, edges, errf);
    check("rd_latency", edges, 32'd2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    check("dat_hold", d_rdat[0], 32'hDEAD_BEEF);

    // Address range / wrap.
    d_xfer(0, 1'b1, 32'h0, 32'hCAFE_0000, rd, edges, errf);
    d_xfer(0, 1'b0, 32'h1000, 32'h0, rd, edges, errf);
`ifdef WB_MEM_ERR_EN
    check("range_err", {31'd0, errf}, 32'd1);
    check("range_dat", rd, 32'd0);
`else
    check("range_err", {31'd0, errf}, 32'd0);
    check("range_wrap", rd, 32'hCAFE_0000);
`endif

    // Fixed-priority arbitration.
    d_xfer(0, 1'b1, 32'h40, 32'h1111_AAAA, rd, edges, errf);
    d_xfer(0, 1'b1, 32'h44, 32'h2222_BBBB, rd, edges, errf);
    arb_run(0, order, nack, both);
    check("arb0_count", nack, 32'd6);
    check("arb0_order", {26'd0, order}, 32'b111000);
    check("arb0_both", both, 32'd0);

    // Round-robin arbitration, WAIT=0.
    d_xfer(1, 1'b1, 32'h40, 32'h1111_AAAA, rd, edges, errf);
    check("w0_latency", edges, 32'd1);
    d_xfer(1, 1'b1, 32'h44, 32'h2222_BBBB, rd, edges, errf);
    arb_run(1, order, nack, both);
    check("arb1_count", nack, 32'd6);
    check("arb1_order", {26'd0, order}, 32'b010101);
    check("arb1_both", both, 32'd0);

    // Back-to-back instruction reads with STB held, WAIT=0.
    d_xfer(1, 1'b1, 32'h0, 32'h11, rd, edges, errf);
    d_xfer(1, 1'b1, 32'h4, 32'h22, rd, edges, errf);
    d_xfer(1, 1'b1, 32'h8, 32'h33, rd, edges, errf);
    @(negedge clk);
    i_stb[1] = 1'b1; i_adr[1] = 32'h0;
    n = 0; cyc = 0; last_cyc = 0; gap_bad = 0;
    while (n < 3 && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (i_akn[1]) begin
        $display("[%0t] dut1 I RD adr=%08h rdat=%08h cyc=%0d", $time, i_adr[1], i_rdat[1], cyc);
        check("b2b_data", i_rdat[1], b2b_exp[n]);
        if (n == 0) check("b2b_first", cyc, 32'd1);
        else check("b2b_gap", cyc - last_cyc, 32'd2);
        last_cyc = cyc;
        n++;
        if (n == 3) i_stb[1] = 1'b0;
        else i_adr[1] = 32'(4 * n);
      end
      if (i_err[1]) gap_bad++;
    end
    i_stb[1] = 1'b0;
    check("b2b_count", n, 32'd3);
    check("b2b_err", gap_bad, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_no_extra", {31'd0, i_akn[1]}, 32'd0);

    // Reset during an uncommitted write, WAIT=5.
    d_xfer(2, 1'b1, 32'h20, 32'h1, rd, edges, errf);
    check("w5_latency", edges, 32'd6);
    d_xfer(2, 1'b0, 32'h20, 32'h0, rd, edges, errf);
    check("w5_rd_old", rd, 32'h1);
    @(negedge clk);
    d_stb[2] = 1'b1; d_we[2] = 1'b1; d_adr[2] = 32'h20; d_wdat[2] = 32'hA5A5_A5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check("rst_async_dat", d_rdat[2], 32'd0);
    akn_seen = d_akn[2];
    repeat (2) begin
      @(negedge clk);
      akn_seen = akn_seen | d_akn[2];
    end
    d_stb[2] = 1'b0; d_we[2] = 1'b0;
    rst_n[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      akn_seen = akn_seen | d_akn[2];
    end
    $display("[%0t] dut2 D WR adr=00000020 wdat=a5a5a5a5 aborted by reset akn_seen=%0b",
             $time, akn_seen);
    check("rst_no_akn", {31'd0, akn_seen}, 32'd0);
    d_xfer(2, 1'b0, 32'h20, 32'h0, rd, edges, errf);
    check("rst_discard", rd, 32'h1);
    check("rst_rd_latency", edges, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
